// File: rtl/imm_field_encoder.sv
// Packs a signed 32-bit value with opcode/registers into instruction words, flagging values that do not fit.
// Build option LI_SPLIT_EN: oversized LI expands into a LUI+ADDI pair instead of a truncated, flagged ADDI.
module imm_field_encoder #(
  parameter logic [5:0] BRA     = 6'b010110,
  parameter logic [5:0] JUMP    = 6'b010101,
  parameter logic [5:0] LI_OP   = 6'b111111,
  parameter logic [5:0] ADDI_OP = 6'b001000
`ifdef LI_SPLIT_EN
  ,
  parameter logic [5:0] LUI_OP  = 6'b001111
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_overflow,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LAST  = 2'd1
`ifdef LI_SPLIT_EN
    ,
    FIRST = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] outInstr_q, outInstr_d;
  logic        outOvf_q, outOvf_d;
  logic [7:0]  errCnt_q, errCnt_d;

  logic        fit16, fit26;
  logic        accept;
  logic [31:0] encWord;
  logic        encOvf;

`ifdef LI_SPLIT_EN
  logic [31:0] pendInstr_q, pendInstr_d;
  logic [31:0] encPend;
  logic        encSplit;
  logic [15:0] liHi;

  // Upper half is pre-compensated for the sign extension ADDI applies to the low half.
  assign liHi = in_value[31:16] + {15'd0, in_value[15]};
`endif

  assign fit16 = (&in_value[31:15]) | ~(|in_value[31:15]);
  assign fit26 = (&in_value[31:25]) | ~(|in_value[31:25]);

  always_comb begin
    encWord = '0;
    encOvf  = 1'b0;
`ifdef LI_SPLIT_EN
    encPend  = '0;
    encSplit = 1'b0;
`endif
    case (in_opcode)
      JUMP: begin
        encWord = {JUMP, in_value[25:0]};
        encOvf  = ~fit26;
      end
      LI_OP: begin
        if (fit16) begin
          encWord = {ADDI_OP, 5'd0, in_rt, in_value[15:0]};
        end else begin
`ifdef LI_SPLIT_EN
          encWord  = {LUI_OP, 5'd0, in_rt, liHi};
          encPend  = {ADDI_OP, in_rt, in_rt, in_value[15:0]};
          encSplit = 1'b1;
`else
          encWord = {ADDI_OP, 5'd0, in_rt, in_value[15:0]};
          encOvf  = 1'b1;
`endif
        end
      end
      BRA: begin
        encWord = {BRA, in_rs, in_rt, in_value[15:0]};
        encOvf  = ~fit16;
      end
      default: begin
        encWord = {in_opcode, in_rs, in_rt, in_value[15:0]};
        encOvf  = ~fit16;
      end
    endcase
  end

  // A new request may only replace the final word of the previous one, never a LUI half.
  assign in_ready = reset_n & ((state_q == EMPTY) | ((state_q == LAST) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    outInstr_d = outInstr_q;
    outOvf_d   = outOvf_q;
    errCnt_d   = errCnt_q;
`ifdef LI_SPLIT_EN
    pendInstr_d = pendInstr_q;
`endif
    if (accept) begin
      outInstr_d = encWord;
      outOvf_d   = encOvf;
      state_d    = LAST;
`ifdef LI_SPLIT_EN
      if (encSplit) begin
        state_d     = FIRST;
        pendInstr_d = encPend;
      end
`endif
      if (encOvf && (errCnt_q != 8'hFF)) begin
        errCnt_d = errCnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        EMPTY: state_d = EMPTY;
        LAST: begin
          if (out_ready) begin
            state_d = EMPTY;
          end
        end
`ifdef LI_SPLIT_EN
        FIRST: begin
          if (out_ready) begin
            state_d    = LAST;
            outInstr_d = pendInstr_q;
            outOvf_d   = 1'b0;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      outInstr_q <= '0;
      outOvf_q   <= 1'b0;
      errCnt_q   <= '0;
`ifdef LI_SPLIT_EN
      pendInstr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      outInstr_q <= outInstr_d;
      outOvf_q   <= outOvf_d;
      errCnt_q   <= errCnt_d;
`ifdef LI_SPLIT_EN
      pendInstr_q <= pendInstr_d;
`endif
    end
  end

  assign out_valid    = (state_q != EMPTY);
  assign out_instr    = outInstr_q;
  assign out_overflow = outOvf_q;
  assign err_count    = errCnt_q;

endmodule
